// File: rtl/ahb3lite_plic_claim_agent.sv
// AHB3-Lite master that claims, presents and completes PLIC interrupts for one target.
// Optional PLIC_CLAIM_STATS_EN adds saturating claim / spurious-claim counters.
module ahb3lite_plic_claim_agent #(
    parameter int unsigned           HADDR_SIZE = 16,
    parameter int unsigned           HDATA_SIZE = 32,
    parameter int unsigned           SOURCES    = 35,
    parameter logic [HADDR_SIZE-1:0] CLAIM_ADDR = 16'h0100,
    localparam int unsigned          IDW        = $clog2(SOURCES + 1)
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  irq,
    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic                  HRESP,
    output logic                  int_valid,
    output logic [IDW-1:0]        int_id,
    input  logic                  int_ack,
`ifdef PLIC_CLAIM_STATS_EN
    output logic [15:0]           claim_cnt,
    output logic [15:0]           spur_cnt,
`endif
    output logic                  bus_err
);

    localparam logic [1:0]     HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]     HTRANS_NONSEQ = 2'b10;
    localparam logic [IDW-1:0] MAX_ID        = IDW'(SOURCES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLAIM_A,
        ST_CLAIM_D,
        ST_HOLD,
        ST_CMPL_A,
        ST_CMPL_D
    } state_e;

    state_e                state_q, state_d;
    logic                  hsel_q, hsel_d;
    logic [1:0]            htrans_q, htrans_d;
    logic                  hwrite_q, hwrite_d;
    logic [HDATA_SIZE-1:0] hwdata_q, hwdata_d;
    logic                  valid_q, valid_d;
    logic [IDW-1:0]        id_q, id_d;
    logic                  bus_err_q, bus_err_d;

    logic [IDW-1:0]        rd_id_c;
    logic                  spurious_c;
    logic                  unused_hrdata_c;

    assign rd_id_c         = HRDATA[IDW-1:0];
    assign spurious_c      = (rd_id_c == '0) || (rd_id_c > MAX_ID);
    assign unused_hrdata_c = ^HRDATA[HDATA_SIZE-1:IDW];

    assign HSEL      = hsel_q;
    assign HADDR     = CLAIM_ADDR;
    assign HWDATA    = hwdata_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HTRANS    = htrans_q;
    assign HMASTLOCK = 1'b0;
    assign int_valid = valid_q;
    assign int_id    = id_q;
    assign bus_err   = bus_err_q;

    // Next-state and registered-output decode; bus control defaults to an idle bus.
    always_comb begin
        state_d   = state_q;
        hsel_d    = 1'b0;
        htrans_d  = HTRANS_IDLE;
        hwrite_d  = 1'b0;
        hwdata_d  = hwdata_q;
        valid_d   = 1'b0;
        id_d      = id_q;
        bus_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (irq) begin
                    state_d  = ST_CLAIM_A;
                    hsel_d   = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                end
            end
            ST_CLAIM_A: begin
                if (HREADY) begin
                    state_d = ST_CLAIM_D;
                end else begin
                    hsel_d   = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                end
            end
            ST_CLAIM_D: begin
                if (HREADY) begin
                    if (HRESP) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        id_d    = rd_id_c;
                        state_d = spurious_c ? ST_IDLE : ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                valid_d = 1'b1;
                // Ack is only meaningful once the core has seen int_valid.
                if (int_ack && valid_q) begin
                    valid_d  = 1'b0;
                    state_d  = ST_CMPL_A;
                    hsel_d   = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                    hwrite_d = 1'b1;
                end
            end
            ST_CMPL_A: begin
                if (HREADY) begin
                    state_d  = ST_CMPL_D;
                    hwdata_d = HDATA_SIZE'(id_q);
                end else begin
                    hsel_d   = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                    hwrite_d = 1'b1;
                end
            end
            ST_CMPL_D: begin
                if (HREADY) begin
                    bus_err_d = HRESP;
                    // A still-pending irq launches the next claim without an IDLE bubble.
                    if (irq) begin
                        state_d  = ST_CLAIM_A;
                        hsel_d   = 1'b1;
                        htrans_d = HTRANS_NONSEQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            hsel_q    <= 1'b0;
            htrans_q  <= HTRANS_IDLE;
            hwrite_q  <= 1'b0;
            hwdata_q  <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hsel_q    <= hsel_d;
            htrans_q  <= htrans_d;
            hwrite_q  <= hwrite_d;
            hwdata_q  <= hwdata_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef PLIC_CLAIM_STATS_EN
    logic        claim_done_c;
    logic [15:0] claim_cnt_q, spur_cnt_q;

    assign claim_done_c = (state_q == ST_CLAIM_D) && HREADY && !HRESP;
    assign claim_cnt    = claim_cnt_q;
    assign spur_cnt     = spur_cnt_q;

    // Saturating event counters.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            claim_cnt_q <= '0;
            spur_cnt_q  <= '0;
        end else begin
            if (claim_done_c && !spurious_c && (claim_cnt_q != 16'hFFFF)) begin
                claim_cnt_q <= claim_cnt_q + 16'd1;
            end
            if (claim_done_c && spurious_c && (spur_cnt_q != 16'hFFFF)) begin
                spur_cnt_q <= spur_cnt_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ahb3lite_plic_claim_agent.sv
// Scoreboard bench for ahb3lite_plic_claim_agent: randomized claims against a timing-level model.
module tb_ahb3lite_plic_claim_agent;

    localparam int unsigned IDW       = 6;
    localparam logic [31:0] CLAIM_A32 = 32'h0000_0100;
    localparam logic [10:0] CTRL_EXP  = {3'b010, 3'b000, 4'b0011, 1'b0};

    logic           HCLK = 1'b0;
    logic           HRESETn, irq, HREADY, HRESP, int_ack;
    logic           HSEL, HWRITE, HMASTLOCK, int_valid, bus_err;
    logic [15:0]    HADDR;
    logic [31:0]    HWDATA, HRDATA;
    logic [2:0]     HSIZE, HBURST;
    logic [3:0]     HPROT;
    logic [1:0]     HTRANS;
    logic [IDW-1:0] int_id;
`ifdef PLIC_CLAIM_STATS_EN
    logic [15:0]    claim_cnt, spur_cnt;
`endif

    ahb3lite_plic_claim_agent dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .irq(irq),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP),
        .int_valid(int_valid), .int_id(int_id), .int_ack(int_ack),
`ifdef PLIC_CLAIM_STATS_EN
        .claim_cnt(claim_cnt), .spur_cnt(spur_cnt),
`endif
        .bus_err(bus_err)
    );

    always #5 HCLK = ~HCLK;

    int unsigned cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef enum int {EV_READ, EV_WRITE, EV_VRISE, EV_VFALL, EV_BERR} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [31:0] a;
        logic [31:0] d;
        int unsigned stamp;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned n_vec   = 0;
    int unsigned n_err   = 0;
    int unsigned n_claim = 0;
    int unsigned n_spur  = 0;
    bit          chained = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push_ev(input ev_kind_e k, input logic [31:0] a, input logic [31:0] d,
                           input int unsigned st);
        ev_t e;
        e.kind = k; e.a = a; e.d = d; e.stamp = st;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e k, input logic [31:0] a, input logic [31:0] d,
                           input int unsigned st);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event actual=%s a=%h d=%h cyc=%0d required=none",
                     k.name(), a, d, st);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a !== a || e.d !== d || e.stamp != st) begin
                n_err++;
                $display("FAIL event actual=%s a=%h d=%h cyc=%0d required=%s a=%h d=%h cyc=%0d",
                         k.name(), a, d, st, e.kind.name(), e.a, e.d, e.stamp);
            end
        end
    endtask

    // Monitor: turns bus/handshake activity into timestamped events for the scoreboard.
    logic        dph = 1'b0, dph_w = 1'b0, aph_wait = 1'b0, v_prev = 1'b0;
    logic [15:0] dph_addr = 16'h0;
    logic [16:0] aph_sig = 17'h0;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dph      = 1'b0;
            aph_wait = 1'b0;
            v_prev   = 1'b0;
        end else begin
            if (dph) begin
                chk("no_pipeline", 32'({HSEL, HTRANS}), 32'd0);
                if (HREADY) begin
                    observe(dph_w ? EV_WRITE : EV_READ, 32'(dph_addr),
                            dph_w ? HWDATA : 32'd0, cyc + 1);
                    dph = 1'b0;
                end
            end else if (HSEL && HTRANS == 2'b10) begin
                if (aph_wait) chk("aph_stable", 32'({HADDR, HWRITE}), 32'(aph_sig));
                chk("ctrl_const", 32'({HSIZE, HBURST, HPROT, HMASTLOCK}), 32'(CTRL_EXP));
                if (HREADY) begin
                    dph      = 1'b1;
                    dph_w    = HWRITE;
                    dph_addr = HADDR;
                    aph_wait = 1'b0;
                end else begin
                    aph_wait = 1'b1;
                    aph_sig  = {HADDR, HWRITE};
                end
            end else if (aph_wait) begin
                chk("aph_held", 32'({HSEL, HTRANS}), 32'd6);
                aph_wait = 1'b0;
            end
            if (int_valid && !v_prev) observe(EV_VRISE, 32'd0, 32'(int_id), cyc);
            if (!int_valid && v_prev) observe(EV_VFALL, 32'd0, 32'd0, cyc);
            v_prev = int_valid;
            if (bus_err) observe(EV_BERR, 32'd0, 32'd0, cyc);
        end
    end

    // One claim: predicts every event from the wait counts, then plays slave and core.
    task automatic do_claim(input logic [31:0] rdata, input bit rerr, input int aw, input int dw,
                            input bit werr, input int aw2, input int dw2, input int hold,
                            input bit chain_next);
        int unsigned    n, e, m, mend;
        int             dwe, dw2e;
        logic [IDW-1:0] id;
        bit             ok;
        id   = rdata[IDW-1:0];
        ok   = !rerr && (id != 6'd0) && (id <= 6'd35);
        dwe  = (rerr && dw == 0) ? 1 : dw;
        dw2e = (werr && dw2 == 0) ? 1 : dw2;
        if (!chained) begin
            irq = 1'b1;
            n = cyc + 1;
            @(negedge HCLK);
        end else begin
            n = cyc;
        end
        e    = n + 2 + aw + dwe;
        m    = e + 2 + hold;
        mend = m + 2 + aw2 + dw2e;
        push_ev(EV_READ, CLAIM_A32, 32'd0, e);
        if (rerr) begin
            push_ev(EV_BERR, 32'd0, 32'd0, e);
        end else if (ok) begin
            push_ev(EV_VRISE, 32'd0, 32'(id), e + 1);
            push_ev(EV_VFALL, 32'd0, 32'd0, m);
            push_ev(EV_WRITE, CLAIM_A32, 32'(id), mend);
            if (werr) push_ev(EV_BERR, 32'd0, 32'd0, mend);
            n_claim++;
        end else begin
            n_spur++;
        end
        repeat (aw) begin
            HREADY = 1'b0; irq = 1'($urandom % 2); int_ack = 1'($urandom % 2);
            @(negedge HCLK);
        end
        HREADY = 1'b1; irq = 1'($urandom % 2); int_ack = 1'($urandom % 2);
        @(negedge HCLK);
        for (int i = 0; i < dwe; i++) begin
            HREADY = 1'b0; HRDATA = $urandom; HRESP = rerr && (i == dwe - 1);
            int_ack = 1'($urandom % 2);
            @(negedge HCLK);
        end
        HREADY = 1'b1; HRDATA = rdata; HRESP = rerr; int_ack = 1'($urandom % 2);
        @(negedge HCLK);
        HRESP = 1'b0; HRDATA = $urandom; int_ack = 1'b0;
        if (!ok) begin
            irq = 1'b0;
        end else begin
            irq = 1'($urandom % 2);
            @(negedge HCLK);
            repeat (hold) begin
                irq = 1'($urandom % 2);
                @(negedge HCLK);
            end
            int_ack = 1'b1; irq = chain_next;
            @(negedge HCLK);
            int_ack = 1'b0;
            repeat (aw2) begin
                HREADY = 1'b0; int_ack = 1'($urandom % 2);
                @(negedge HCLK);
            end
            HREADY = 1'b1; int_ack = 1'($urandom % 2);
            @(negedge HCLK);
            for (int i = 0; i < dw2e; i++) begin
                HREADY = 1'b0; HRESP = werr && (i == dw2e - 1); int_ack = 1'($urandom % 2);
                @(negedge HCLK);
            end
            HREADY = 1'b1; HRESP = werr; int_ack = 1'($urandom % 2);
            @(negedge HCLK);
            HRESP = 1'b0; int_ack = 1'b0;
        end
        chained = ok && chain_next;
        if (!chained) irq = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            irq = 1'b0; int_ack = 1'($urandom % 2); HREADY = 1'($urandom % 2); HRDATA = $urandom;
            @(negedge HCLK);
        end
        HREADY = 1'b1; int_ack = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_HSEL"},      32'(HSEL),      32'd0);
        chk({tag, "_HTRANS"},    32'(HTRANS),    32'd0);
        chk({tag, "_HWRITE"},    32'(HWRITE),    32'd0);
        chk({tag, "_HWDATA"},    HWDATA,         32'd0);
        chk({tag, "_int_valid"}, 32'(int_valid), 32'd0);
        chk({tag, "_int_id"},    32'(int_id),    32'd0);
        chk({tag, "_bus_err"},   32'(bus_err),   32'd0);
`ifdef PLIC_CLAIM_STATS_EN
        chk({tag, "_claim_cnt"}, 32'(claim_cnt), 32'd0);
        chk({tag, "_spur_cnt"},  32'(spur_cnt),  32'd0);
`endif
    endtask

    // Reset while a claim is in flight at the given stage (0 addr, 1 data, 2 holding).
    task automatic reset_at(input int stage);
        int unsigned n;
        irq = 1'b1; n = cyc + 1;
        @(negedge HCLK);
        HREADY = (stage > 0);
        if (stage == 0) chk("pre_rst_HSEL", 32'(HSEL), 32'd1);
        @(negedge HCLK);
        if (stage == 2) begin
            HRDATA = 32'd7; HREADY = 1'b1;
            push_ev(EV_READ, CLAIM_A32, 32'd0, n + 2);
            push_ev(EV_VRISE, 32'd0, 32'd7, n + 3);
            @(negedge HCLK);
            @(negedge HCLK);
            chk("pre_rst_int_valid", 32'(int_valid), 32'd1);
        end else begin
            HREADY = 1'b0;
        end
        #2 HRESETn = 1'b0;
        #1 reset_checks("midrst");
        exp_q.delete();
        n_claim = 0; n_spur = 0; chained = 1'b0;
        HREADY = 1'b1;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        do_claim(32'd9, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
        idle(2);
    endtask

    initial begin
        logic [31:0] rdata;
        logic [5:0]  idv;
        logic [25:0] up;
        int          r;
        HRESETn = 1'b1; irq = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0; int_ack = 1'b0;
        #1 HRESETn = 1'b0;
        #1 reset_checks("rst");
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        do_claim(32'h5, 1'b0, 0, 0, 1'b0, 0, 0, 1, 1'b0);            idle(2);
        do_claim(32'h11, 1'b0, 2, 2, 1'b0, 2, 2, 0, 1'b0);           idle(2);
        do_claim(32'h0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0);            idle(2);
        do_claim(32'd40, 1'b0, 1, 0, 1'b0, 0, 0, 0, 1'b0);           idle(3);
`ifdef PLIC_CLAIM_STATS_EN
        chk("spur_cnt_two", 32'(spur_cnt), 32'd2);
`endif
        do_claim(32'h3, 1'b1, 0, 1, 1'b0, 0, 0, 0, 1'b0);            idle(2);
        do_claim(32'h3, 1'b0, 0, 0, 1'b0, 1, 0, 2, 1'b0);            idle(2);
        do_claim(32'h8, 1'b0, 0, 0, 1'b1, 0, 1, 0, 1'b0);            idle(2);
        for (int s = 0; s < 3; s++) reset_at(s);
        do_claim(32'd21, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
        do_claim(32'd22, 1'b0, 1, 0, 1'b0, 0, 1, 2, 1'b1);
        do_claim(32'd35, 1'b0, 0, 0, 1'b0, 0, 0, 1, 1'b0);           idle(2);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 7);
            if (r <= 4)      idv = 6'($urandom_range(1, 35));
            else if (r == 5) idv = 6'd0;
            else             idv = 6'($urandom_range(36, 63));
            up    = ($urandom % 4 == 0) ? 26'($urandom) : 26'd0;
            rdata = {up, idv};
            do_claim(rdata, ($urandom % 8 == 0), $urandom_range(0, 2), $urandom_range(0, 2),
                     ($urandom % 8 == 0), $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 4), (i != 59) && ($urandom % 3 == 0));
            if (!chained) idle($urandom_range(0, 3));
        end

        idle(10);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef PLIC_CLAIM_STATS_EN
        chk("claim_cnt", 32'(claim_cnt), 32'(n_claim));
        chk("spur_cnt",  32'(spur_cnt),  32'(n_spur));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb3lite_plic_claim_agent.md
# ahb3lite_plic_claim_agent

AHB3-Lite master that services one PLIC interrupt target on behalf of a core that has no bus-level interrupt handling. It watches the target's `irq` line, reads the PLIC claim register, presents the claimed source ID to the core over a valid/ack handshake, then writes the ID back to the claim/complete register. It sits directly downstream of `ahb3lite_plic_top`: it consumes one `irq` bit and drives that block's AHB slave port.

## Interface
- `HADDR_SIZE`, 16, AHB address width
- `HDATA_SIZE`, 32, AHB data width
- `SOURCES`, 35, number of PLIC sources; ID width `IDW = $clog2(SOURCES+1)`
- `CLAIM_ADDR`, 16'h0100, byte address of this target's claim/complete register

Ports:
- `HCLK` in 1: clock, rising edge
- `HRESETn` in 1: asynchronous active-low reset
- `irq` in 1: PLIC interrupt request for this target
- `HSEL` out 1: slave select
- `HADDR` out HADDR_SIZE: address
- `HWDATA` out HDATA_SIZE: write data
- `HRDATA` in HDATA_SIZE: read data
- `HWRITE` out 1: write
- `HSIZE` out 3: transfer size
- `HBURST` out 3: burst type
- `HPROT` out 4: protection
- `HTRANS` out 2: transfer type
- `HMASTLOCK` out 1: locked transfer
- `HREADY` in 1: transfer done / bus ready
- `HRESP` in 1: error response
- `int_valid` out 1: claimed ID is valid
- `int_id` out IDW: claimed source ID
- `int_ack` in 1: core has finished handling; triggers complete
- `bus_err` out 1: one-cycle pulse on an HRESP error

## Operation
- Constant outputs: `HSIZE`=3'b010, `HBURST`=3'b000, `HPROT`=4'b0011, `HMASTLOCK`=0, `HADDR`=CLAIM_ADDR.
- FSM states: IDLE, CLAIM_A, CLAIM_D, HOLD, CMPL_A, CMPL_D.
- IDLE: if `irq`=1, go to CLAIM_A.
- CLAIM_A: drive `HSEL`=1, `HTRANS`=NONSEQ (2'b10), `HWRITE`=0. When `HREADY`=1, go to CLAIM_D. Otherwise hold the address phase.
- CLAIM_D: drive `HTRANS`=IDLE and `HSEL`=0. When `HREADY`=1:
  - `HRESP`=1: pulse `bus_err` and go to IDLE.
  - Otherwise capture `HRDATA[IDW-1:0]` into `int_id`.
  - ID 0, or ID > SOURCES, is spurious: go to IDLE with no `int_valid` and no complete.
  - Any other ID: go to HOLD.
- HOLD: `int_valid`=1. When `int_ack`=1, go to CMPL_A. `irq` is ignored in this state.
- CMPL_A: drive `HSEL`=1, `HTRANS`=NONSEQ, `HWRITE`=1. When `HREADY`=1, go to CMPL_D.
- CMPL_D: drive `HWDATA`={zero-extended `int_id`}, `HTRANS`=IDLE. When `HREADY`=1, go to IDLE; if `HRESP`=1, also pulse `bus_err`.
- A single transfer is outstanding at a time. Back-to-back pipelining is never issued.
- `int_ack` is only honoured in HOLD; it is ignored in every other state.

## Timing
- All outputs are registered. Reset values:
  - `HSEL`=0, `HTRANS`=2'b00, `HWRITE`=0, `HWDATA`=0.
  - `int_valid`=0, `int_id`=0, `bus_err`=0.
  - State = IDLE.
- Reset is asynchronous. Asserting `HRESETn` at any point, including mid-transfer, forces the reset values immediately. No complete is issued for an ID that was in flight.
- Latency with a zero-wait slave:
  - `irq` high sampled at edge N: address phase during cycle N+1, data phase during cycle N+2.
  - `int_valid` rises after edge N+3.
- Wait states: each `HREADY`=0 cycle in an address or data phase adds exactly one cycle. Address-phase outputs stay stable throughout the wait.
- `int_ack` sampled at edge M in HOLD:
  - `int_valid` falls after edge M.
  - Complete address phase is in cycle M+1, data phase in cycle M+2.
  - Earliest return to IDLE is after edge M+2; the next claim address phase is then in cycle M+3.
- `int_valid` stays high until acked, regardless of `irq`.
- `bus_err` lasts one cycle, in the cycle after the erroring data phase completes.

## Configuration
- Macro `PLIC_CLAIM_STATS_EN` adds two outputs, `claim_cnt` [15:0] and `spur_cnt` [15:0], both reset to 0.
  - `claim_cnt` increments on each valid claim (entry to HOLD).
  - `spur_cnt` increments on each spurious claim.
  - Both saturate at 16'hFFFF.
- Without the macro, these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Zero-wait claim: `irq`=1 and the slave returns 32'h5 → NONSEQ read to 16'h0100, `int_valid` with `int_id`=5 three cycles after `irq` is sampled. `int_ack`=1 → NONSEQ write to 16'h0100 with `HWDATA`=32'h5, then IDLE.
- Wait states: `HREADY`=0 for 2 cycles in each phase → `HADDR`/`HTRANS`/`HWRITE` stay stable, and `int_valid` is delayed by exactly 4 cycles versus the zero-wait case.
- Spurious: the slave returns 0, and in a separate run returns 40 → no `int_valid`, no write, FSM back to IDLE. With `PLIC_CLAIM_STATS_EN`, `spur_cnt`=2.
- Error: `HRESP`=1 on the claim data phase → one-cycle `bus_err`, no `int_valid`, IDLE. A later claim with ID 3 completes normally.
- Reset mid-transfer: drive `HRESETn` low during CLAIM_D → `HTRANS`=00, `HSEL`=0 and `int_valid`=0 immediately. After release with `irq`=1, a fresh claim starts.
- Sustained `irq`: `irq` held high across HOLD → no second claim until the complete finishes. The next claim address phase appears in the cycle after CMPL_D completes.
